csma_tx_ctrl: RTL and testbench

- CSMA/CD transmit controller for the half-duplex MAC.
- Sits directly upstream of the backoff random generator: drives its init and retry_count and consumes its trigger.
- Arbitrates frame start against carrier sense and the inter-frame gap, and runs jam after a collision.
- Counts attempts, drives the backoff handshake, and reports success, excessive-collision abort or late-collision abort to the TX datapath.

---
 rtl/mac_pkg.sv | 32 +++
 rtl/csma_tx_ctrl_if.sv | 32 +++
 rtl/mac_cycle_timer.sv | 38 +++
 rtl/csma_tx_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_csma_tx_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared MAC types and constants for the half-duplex transmit path.
package mac_pkg;

    localparam int unsigned RETRY_W       = 4;
    localparam int unsigned COLL_CNT_W    = 5;
    // Highest backoff exponent index; the random generator sizes its draw from this.
    localparam int unsigned BACKOFF_LIMIT = 9;

    typedef enum logic [2:0] {
        StIdle,
        StDefer,
        StIfg,
        StTransmit,
        StJam,
        StBoStart,
        StBoWait
    } csma_state_t;

    // Backoff exponent index for a given collision count: min(count-1, BACKOFF_LIMIT).
    function automatic logic [RETRY_W-1:0] retry_index(input logic [COLL_CNT_W-1:0] coll_cnt);
        logic [COLL_CNT_W-1:0] idx;
        if (coll_cnt == '0) begin
            return '0;
        end
        idx = coll_cnt - COLL_CNT_W'(1);
        if (idx > COLL_CNT_W'(BACKOFF_LIMIT)) begin
            return RETRY_W'(BACKOFF_LIMIT);
        end
        return idx[RETRY_W-1:0];
    endfunction

endpackage

// File: rtl/csma_tx_ctrl_if.sv
// Handshake bundle between the CSMA/CD controller and the TX datapath, PHY status and
// backoff generator. The controller takes the master side.
interface csma_tx_ctrl_if;
    import mac_pkg::*;

    logic                  tx_request;
    logic                  tx_done;
    logic                  carrier_sense;
    logic                  collision;
    logic                  backoff_done;
    logic                  tx_start;
    logic                  jam;
    logic                  backoff_init;
    logic [RETRY_W-1:0]    retry_count;
    logic                  tx_success;
    logic                  tx_abort;
    logic                  late_collision;
    logic [COLL_CNT_W-1:0] collision_count;

    modport master (
        input  tx_request, tx_done, carrier_sense, collision, backoff_done,
        output tx_start, jam, backoff_init, retry_count, tx_success, tx_abort,
               late_collision, collision_count
    );

    modport slave (
        output tx_request, tx_done, carrier_sense, collision, backoff_done,
        input  tx_start, jam, backoff_init, retry_count, tx_success, tx_abort,
               late_collision, collision_count
    );

endinterface

// File: rtl/mac_cycle_timer.sv
// Load/enable up-counter with a terminal-count compare; shared between IFG and jam timing.
module mac_cycle_timer #(
    parameter int unsigned Width = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [Width-1:0] term_i,
    output logic [Width-1:0] count_o,
    output logic             tc_o
);

    logic [Width-1:0] count_q, count_d;

    // Load restarts from zero and takes priority over counting.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + Width'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/csma_tx_ctrl.sv
// CSMA/CD transmit controller: deferral, inter-frame gap, collision jam, attempt counting
// and backoff handshake. All outputs are registered.
module csma_tx_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned IFG_CYCLES   = 24,
    parameter int unsigned IFG_PART1    = 16,
    parameter int unsigned JAM_CYCLES   = 8,
    parameter int unsigned COLL_WINDOW  = 128,
    parameter int unsigned MAX_ATTEMPTS = 16
) (
    input  logic           clock,
    input  logic           reset,
    csma_tx_ctrl_if.master bus
);

    localparam int unsigned TimerMax = (IFG_CYCLES > JAM_CYCLES) ? IFG_CYCLES : JAM_CYCLES;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);
    localparam int unsigned WinW     = $clog2(COLL_WINDOW + 1);
    localparam logic [WinW-1:0] WinMax = WinW'(COLL_WINDOW);

    csma_state_t           state_q, state_d;
    logic [WinW-1:0]       win_q, win_d;
    logic                  late_q, late_d;
    logic [COLL_CNT_W-1:0] coll_cnt_q, coll_cnt_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic                  tx_start_q, tx_start_d;
    logic                  jam_q, jam_d;
    logic                  bo_init_q, bo_init_d;
    logic                  success_q, success_d;
    logic                  abort_q, abort_d;
    logic                  late_coll_q, late_coll_d;

    logic                  tmr_load, tmr_en, tmr_tc;
    logic [TimerW-1:0]     tmr_term, tmr_count;

    mac_cycle_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk_i   (clock),
        .rst_ni  (reset),
        .load_i  (tmr_load),
        .en_i    (tmr_en),
        .term_i  (tmr_term),
        .count_o (tmr_count),
        .tc_o    (tmr_tc)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        late_d      = late_q;
        coll_cnt_d  = coll_cnt_q;
        tx_start_d  = 1'b0;
        success_d   = 1'b0;
        abort_d     = 1'b0;
        late_coll_d = 1'b0;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        tmr_term    = TimerW'(IFG_CYCLES - 1);

        unique case (state_q)
            StIdle: begin
                if (bus.tx_request) begin
                    state_d    = StDefer;
                    coll_cnt_d = '0;
                end
            end
            StDefer: begin
                if (!bus.carrier_sense) begin
                    state_d  = StIfg;
                    tmr_load = 1'b1;
                end
            end
            StIfg: begin
                tmr_en = 1'b1;
                // Carrier only restarts deferral in the first part of the gap.
                if (bus.carrier_sense && (tmr_count < TimerW'(IFG_PART1))) begin
                    state_d = StDefer;
                end else if (tmr_tc) begin
                    state_d    = StTransmit;
                    tx_start_d = 1'b1;
                    win_d      = '0;
                end
            end
            StTransmit: begin
                if (win_q != WinMax) begin
                    win_d = win_q + WinW'(1);
                end
                // Collision beats a coincident tx_done.
                if (bus.collision) begin
                    state_d  = StJam;
                    tmr_load = 1'b1;
                    late_d   = (win_q == WinMax);
                    if (coll_cnt_q != '1) begin
                        coll_cnt_d = coll_cnt_q + COLL_CNT_W'(1);
                    end
                end else if (bus.tx_done) begin
                    state_d   = StIdle;
                    success_d = 1'b1;
                end
            end
            StJam: begin
                tmr_en   = 1'b1;
                tmr_term = TimerW'(JAM_CYCLES - 1);
                if (tmr_tc) begin
                    if (late_q) begin
                        state_d     = StIdle;
                        abort_d     = 1'b1;
                        late_coll_d = 1'b1;
                    end else if (coll_cnt_q == COLL_CNT_W'(MAX_ATTEMPTS)) begin
                        state_d = StIdle;
                        abort_d = 1'b1;
                    end else begin
                        state_d = StBoStart;
                    end
                end
            end
            StBoStart: begin
                state_d = StBoWait;
            end
            StBoWait: begin
                if (bus.backoff_done) begin
                    state_d = StDefer;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        jam_d     = (state_d == StJam);
        bo_init_d = (state_d == StBoStart);

        // Exponent index is captured entering BO_START and held only while backing off.
        if (state_d == StBoStart) begin
            retry_d = retry_index(coll_cnt_q);
        end else if (state_d == StBoWait) begin
            retry_d = retry_q;
        end else begin
            retry_d = '0;
        end
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            win_q       <= '0;
            late_q      <= 1'b0;
            coll_cnt_q  <= '0;
            retry_q     <= '0;
            tx_start_q  <= 1'b0;
            jam_q       <= 1'b0;
            bo_init_q   <= 1'b0;
            success_q   <= 1'b0;
            abort_q     <= 1'b0;
            late_coll_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            late_q      <= late_d;
            coll_cnt_q  <= coll_cnt_d;
            retry_q     <= retry_d;
            tx_start_q  <= tx_start_d;
            jam_q       <= jam_d;
            bo_init_q   <= bo_init_d;
            success_q   <= success_d;
            abort_q     <= abort_d;
            late_coll_q <= late_coll_d;
        end
    end

    assign bus.tx_start        = tx_start_q;
    assign bus.jam             = jam_q;
    assign bus.backoff_init    = bo_init_q;
    assign bus.retry_count     = retry_q;
    assign bus.tx_success      = success_q;
    assign bus.tx_abort        = abort_q;
    assign bus.late_collision  = late_coll_q;
    assign bus.collision_count = coll_cnt_q;

endmodule

// File: tb/tb_csma_tx_ctrl.sv
// Directed bench for csma_tx_ctrl: output events are captured by a monitor and matched
// in order against events the stimulus predicts.
module tb_csma_tx_ctrl;
    import mac_pkg::*;

    typedef enum logic [2:0] {EvStart, EvSuccess, EvAbort, EvBoInit, EvJam, EvLate} ev_kind_e;

    typedef struct packed {
        ev_kind_e    kind;
        logic [31:0] at;
        logic [7:0]  len;
        logic [4:0]  coll;
        logic [3:0]  retry;
        logic        late;
    } ev_t;

    logic clock;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    csma_tx_ctrl_if bus ();

    csma_tx_ctrl #(
        .IFG_CYCLES   (24),
        .IFG_PART1    (16),
        .JAM_CYCLES   (8),
        .COLL_WINDOW  (128),
        .MAX_ATTEMPTS (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic ev_t mk(ev_kind_e k, int at, int len, int coll, int retry, logic late);
        ev_t e;
        e.kind  = k;
        e.at    = at;
        e.len   = 8'(len);
        e.coll  = 5'(coll);
        e.retry = 4'(retry);
        e.late  = late;
        return e;
    endfunction

    // Monitor: samples on the falling edge and records every pulse and each jam burst.
    initial begin
        logic jam_prev;
        int   jam_start;
        int   jam_len;
        jam_prev  = 1'b0;
        jam_start = 0;
        jam_len   = 0;
        forever begin
            @(negedge clock);
            if (bus.jam === 1'b1) begin
                if (!jam_prev) begin
                    jam_start = cyc;
                    jam_len   = 0;
                end
                jam_len++;
            end else if (jam_prev) begin
                obs_q.push_back(mk(EvJam, jam_start, jam_len, 0, 0, 1'b0));
            end
            jam_prev = (bus.jam === 1'b1);
            if (bus.tx_start === 1'b1)
                obs_q.push_back(mk(EvStart, cyc, 0, bus.collision_count, bus.retry_count,
                                   bus.late_collision));
            if (bus.tx_success === 1'b1)
                obs_q.push_back(mk(EvSuccess, cyc, 0, bus.collision_count, bus.retry_count,
                                   bus.late_collision));
            if (bus.tx_abort === 1'b1)
                obs_q.push_back(mk(EvAbort, cyc, 0, bus.collision_count, bus.retry_count,
                                   bus.late_collision));
            if (bus.backoff_init === 1'b1)
                obs_q.push_back(mk(EvBoInit, cyc, 0, bus.collision_count, bus.retry_count,
                                   bus.late_collision));
            if (bus.late_collision === 1'b1 && bus.tx_abort !== 1'b1)
                obs_q.push_back(mk(EvLate, cyc, 0, bus.collision_count, 0, 1'b1));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic push(input ev_t e);
        exp_q.push_back(e);
    endtask

    // Pop expected events in order and compare against observed ones (bounded wait).
    task automatic drain(input string tag);
        int  budget;
        ev_t e;
        ev_t o;
        budget = 300;
        while (obs_q.size() < exp_q.size() && budget > 0) begin
            tick(1);
            budget--;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            else o = ev_t'('1);
            vectors++;
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s: observed kind=%0d at=%0d len=%0d coll=%0d retry=%0d late=%0d; expected kind=%0d at=%0d len=%0d coll=%0d retry=%0d late=%0d",
                       tag, o.kind, o.at, o.len, o.coll, o.retry, o.late,
                       e.kind, e.at, e.len, e.coll, e.retry, e.late);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        logic [14:0] v;
        v = {bus.tx_start, bus.jam, bus.backoff_init, bus.tx_success, bus.tx_abort,
             bus.late_collision, bus.retry_count, bus.collision_count};
        vectors++;
        assert (v === 15'b0) else begin
            miscompares++;
            $error("FAIL %s: observed outputs=%h expected %h", tag, v, 15'b0);
        end
    endtask

    task automatic req_pulse();
        bus.tx_request = 1'b1;
        tick(1);
        bus.tx_request = 1'b0;
    endtask

    task automatic pulse_at(input int c, input int which);
        wait_until(c);
        case (which)
            0: bus.tx_done = 1'b1;
            1: bus.collision = 1'b1;
            default: bus.backoff_done = 1'b1;
        endcase
        tick(1);
        bus.tx_done      = 1'b0;
        bus.collision    = 1'b0;
        bus.backoff_done = 1'b0;
    endtask

    initial begin
        int c0;
        int t;
        int c;
        int r;
        logic [8:0] st;

        reset             = 1'b0;
        bus.tx_request    = 1'b0;
        bus.tx_done       = 1'b0;
        bus.carrier_sense = 1'b0;
        bus.collision     = 1'b0;
        bus.backoff_done  = 1'b0;
        tick(3);
        chk_zero("reset_outputs");
        reset = 1'b1;
        tick(2);
        chk_zero("idle_outputs");

        // 1: clean frame on an idle medium.
        c0 = cyc;
        req_pulse();
        t = c0 + 26;
        push(mk(EvStart, t, 0, 0, 0, 1'b0));
        pulse_at(t + 60, 0);
        push(mk(EvSuccess, t + 61, 0, 0, 0, 1'b0));
        drain("t1_clean");

        // 2: carrier at IFG count 10 restarts the gap; carrier at counts 16..20 ignored.
        c0 = cyc;
        req_pulse();
        wait_until(c0 + 12);
        bus.carrier_sense = 1'b1;
        tick(1);
        bus.carrier_sense = 1'b0;
        wait_until(c0 + 14 + 16);
        bus.carrier_sense = 1'b1;
        tick(5);
        bus.carrier_sense = 1'b0;
        t = c0 + 14 + 24;
        push(mk(EvStart, t, 0, 0, 0, 1'b0));
        pulse_at(t + 5, 0);
        push(mk(EvSuccess, t + 6, 0, 0, 0, 1'b0));
        drain("t2_ifg");

        // 3: collision mid-frame; extra collisions during jam and backoff are ignored.
        c0 = cyc;
        req_pulse();
        t = c0 + 26;
        push(mk(EvStart, t, 0, 0, 0, 1'b0));
        c = t + 40;
        wait_until(c);
        bus.collision = 1'b1;
        tick(3);
        bus.collision = 1'b0;
        push(mk(EvJam, c + 1, 8, 0, 0, 1'b0));
        push(mk(EvBoInit, c + 9, 0, 1, 0, 1'b0));
        wait_until(c + 10);
        bus.backoff_done = 1'b1;
        bus.collision    = 1'b1;
        tick(1);
        bus.backoff_done = 1'b0;
        bus.collision    = 1'b0;
        t = c + 36;
        push(mk(EvStart, t, 0, 1, 0, 1'b0));
        pulse_at(t + 20, 0);
        push(mk(EvSuccess, t + 21, 0, 1, 0, 1'b0));
        drain("t3_collision");

        // 4: collide on every attempt until excessive-collision abort.
        c0 = cyc;
        req_pulse();
        t = c0 + 26;
        push(mk(EvStart, t, 0, 0, 0, 1'b0));
        for (int k = 1; k <= 16; k++) begin
            c = t + 1;
            pulse_at(c, 1);
            push(mk(EvJam, c + 1, 8, 0, 0, 1'b0));
            if (k < 16) begin
                push(mk(EvBoInit, c + 9, 0, k, (k - 1 > 9) ? 9 : k - 1, 1'b0));
                pulse_at(c + 10, 2);
                t = c + 36;
                push(mk(EvStart, t, 0, k, 0, 1'b0));
            end else begin
                push(mk(EvAbort, c + 9, 0, 16, 0, 1'b0));
            end
        end
        drain("t4_excessive");
        tick(2);
        vectors++;
        assert (bus.collision_count === 5'd16) else begin
            miscompares++;
            $error("FAIL t4_count_hold: observed %0d expected %0d", bus.collision_count, 16);
        end
        vectors++;
        assert (bus.retry_count === 4'd0) else begin
            miscompares++;
            $error("FAIL t4_retry_idle: observed %0d expected %0d", bus.retry_count, 0);
        end

        // 5: collision at window 127 is normal, at 128 it is late.
        c0 = cyc;
        req_pulse();
        t = c0 + 26;
        push(mk(EvStart, t, 0, 0, 0, 1'b0));
        c = t + 127;
        pulse_at(c, 1);
        push(mk(EvJam, c + 1, 8, 0, 0, 1'b0));
        push(mk(EvBoInit, c + 9, 0, 1, 0, 1'b0));
        pulse_at(c + 10, 2);
        t = c + 36;
        push(mk(EvStart, t, 0, 1, 0, 1'b0));
        c = t + 128;
        pulse_at(c, 1);
        push(mk(EvJam, c + 1, 8, 0, 0, 1'b0));
        push(mk(EvAbort, c + 9, 0, 2, 0, 1'b1));
        drain("t5_late");

        // 6: reset during BO_WAIT, released with a request pending.
        c0 = cyc;
        req_pulse();
        t = c0 + 26;
        push(mk(EvStart, t, 0, 0, 0, 1'b0));
        c = t + 10;
        pulse_at(c, 1);
        push(mk(EvJam, c + 1, 8, 0, 0, 1'b0));
        push(mk(EvBoInit, c + 9, 0, 1, 0, 1'b0));
        wait_until(c + 11);
        reset          = 1'b0;
        bus.tx_request = 1'b1;
        tick(1);
        chk_zero("t6_reset_a");
        bus.backoff_done = 1'b1;
        tick(1);
        chk_zero("t6_reset_b");
        bus.backoff_done = 1'b0;
        st = {1'b0, dut.state_q == StIdle, 7'b0};
        vectors++;
        assert (st === 9'h080) else begin
            miscompares++;
            $error("FAIL t6_state_idle: observed %h expected %h", st, 9'h080);
        end
        r = cyc;
        reset = 1'b1;
        tick(1);
        bus.tx_request = 1'b0;
        t = r + 26;
        push(mk(EvStart, t, 0, 0, 0, 1'b0));
        pulse_at(t + 3, 0);
        push(mk(EvSuccess, t + 4, 0, 0, 0, 1'b0));
        drain("t6_reset");

        tick(5);
        vectors++;
        assert (obs_q.size() === 0) else begin
            miscompares++;
            $error("FAIL leftover_events: observed %0d expected %0d", obs_q.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
